salsa20_stream_ctrl: RTL and testbench
======================================

// Module: salsa20_stream_ctrl
// PURPOSE
//  Sequencer between a 64-bit AXI-style word stream and one Salsa20 core.
//  - On start: programs the core register file (SETUP, KEY0..KEY3, NONCE), pulses init
//    and waits for ready.
//  - Streams message words through the core's data_encdec port into a 2-entry output FIFO.
//  - After the last word: pulses the core reset so the next message restarts at block 0.
// PARAMETERS
//  FIFO_DEPTH  2   output FIFO entries (fixed 2; other values unsupported)
//  MAX_WORDS   0   max words per message; 0 = unlimited; excess sets err
// PORTS
//  clk          in   1    single clock, all logic rising-edge
//  rst_n        in   1    async active-low reset
//  cfg_key      in   256  key; KEY0=[63:0] .. KEY3=[255:192], sampled at start
//  cfg_nonce    in   64   nonce, sampled at start
//  cfg_key256   in   1    1=32-byte key, 0=16-byte key (SETUP bit0)
//  cfg_rounds   in   4    round count (SETUP bits[4:1])
//  start        in   1    begin message; ignored unless busy=0
//  busy         out  1    high from start accept until return to IDLE
//  err          out  1    sticky overflow (MAX_WORDS exceeded); cleared by start
//  s_data       in   64   input word (plaintext or ciphertext)
//  s_last       in   1    final word of message
//  s_valid      in   1    input word valid
//  s_ready      out  1    input word accepted when s_valid & s_ready
//  m_data       out  64   result word
//  m_last       out  1    final result word
//  m_valid      out  1    FIFO head valid
//  m_ready      in   1    sink accepts when m_valid & m_ready
//  core_rst     out  1    active-high core reset
//  core_we      out  1    core register write strobe
//  core_addr    out  3    0..3=KEY0..3, 4=NONCE, 5=SETUP
//  core_wdata   out  64   core register data / stream word
//  core_init    out  1    1-cycle init pulse
//  core_encdec  out  1    stream word presented
//  core_ready   in   1    core initialised / keystream block available
//  core_valid   in   1    core_out holds the result for the presented word
//  core_out     in   64   core result
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; FIFO empty; busy=err=core_we=core_init=core_encdec=0;
//   core_rst=1 while rst_n low and for 1 cycle after release; core_addr=0; core_wdata=0;
//   s_ready=m_valid=m_last=0. Reset mid-message discards all in-flight and FIFO data.
//  FSM: IDLE -> CFG -> INIT -> WAIT_RDY -> STREAM -> DRAIN -> CRST -> IDLE.
//  IDLE: start=1 latches cfg_*, clears err, word count=0; next CFG; busy=1 next cycle.
//  CFG: 6 consecutive cycles with core_we=1, core_addr = 5,0,1,2,3,4;
//   core_wdata = {59'b0, cfg_rounds, cfg_key256}, then KEY0..KEY3, NONCE.
//  INIT: core_we=0, core_init=1 for exactly 1 cycle.
//  WAIT_RDY: hold until core_ready=1, then STREAM.
//  STREAM:
//   - Holding register W (data, last, full flag). s_ready = !W.full | retire.
//   - core_encdec = W.full & (FIFO entries + 1 <= FIFO_DEPTH); core_wdata = W.data.
//   - Retire = core_encdec & core_valid. On retire, {core_out, W.last} is pushed to the
//     FIFO in the same edge; W refills from s_* in the same edge (zero-bubble).
//   - core_valid=0 while core_encdec=1 (keystream rollover): W and core_wdata held stable;
//     no push.
//   - FIFO full: core_encdec=0; W held.
//   - Word count increments on each input accept; accept of word MAX_WORDS+1 sets err.
//     Data is still processed.
//   - Retire of a word with last=1 -> DRAIN; s_ready=0 from then on.
//  DRAIN: wait for FIFO empty -> CRST.
//  CRST: core_rst=1 for 1 cycle, then IDLE; busy=0 once in IDLE.
//  FIFO: push and pop in the same cycle when full is legal; count unchanged.
//   m_data/m_last/m_valid are registered from FIFO head; m_data holds while m_valid & !m_ready.
//  Latency: input accept -> m_valid is 2 cycles minimum (W register, then FIFO).
//  start while busy: ignored. s_valid outside STREAM: s_ready=0, no accept.
// TESTING
//  1 Config: start, key256=1, rounds=10 -> 6 writes addr 5,0,1,2,3,4 with wdata[4:0]=5'b10101;
//    then 1 init pulse.
//  2 Stream: 88 words (11 blocks) vs golden Salsa20/20 vectors, m_ready=1 -> bit-exact output;
//    back-to-back accepts except rollover stalls; m_last on word 88.
//  3 Backpressure: m_ready=0 for 10 cycles mid-block -> m_valid held, m_data stable,
//    core_encdec=0 once FIFO full, no loss or duplication.
//  4 Rollover: core_valid=0 for 3 cycles while encdec=1 -> core_wdata unchanged;
//    result order preserved.
//  5 Back-to-back messages: second start after busy=0 -> core_rst pulse seen, config rewritten;
//    decrypting ciphertext of msg 1 restores plaintext.
//  6 Async reset mid-STREAM: rst_n low 1 cycle -> all outputs reach reset values
//    immediately, FIFO empty; a new start works.

Source files
------------

// File: rtl/salsa20_stream_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// salsa20_stream_ctrl
//   Sequences one Salsa20 core for a 64-bit valid/ready word stream.
//   On start it writes the core register file (SETUP, KEY0..KEY3, NONCE),
//   pulses init and waits for the core to report ready. It then passes each
//   message word through the core's encdec port into a 2-entry output FIFO.
//   After the last word has drained, it pulses the core reset so the next
//   message restarts at keystream block 0.
//
// Ports
//   i_clk, i_rst_n             clock, async active-low reset
//   i_cfg_*                    key / nonce / key size / rounds, sampled at start
//   i_start, o_busy, o_err     message control; o_err is the sticky overflow flag
//   i_s_* / o_s_ready          input word stream
//   o_m_* / i_m_ready          result word stream (registered FIFO head)
//   o_core_*, i_core_*         Salsa20 core register/stream interface
// ---------------------------------------------------------------------------
module salsa20_stream_ctrl #(
    parameter int FIFO_DEPTH = 2,   // the FIFO is built as head + tail; only 2 is supported
    parameter int MAX_WORDS  = 0    // 0 = unlimited
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [255:0] i_cfg_key,
    input  logic [63:0]  i_cfg_nonce,
    input  logic         i_cfg_key256,
    input  logic [3:0]   i_cfg_rounds,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_err,
    input  logic [63:0]  i_s_data,
    input  logic         i_s_last,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    output logic [63:0]  o_m_data,
    output logic         o_m_last,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic         o_core_rst,
    output logic         o_core_we,
    output logic [2:0]   o_core_addr,
    output logic [63:0]  o_core_wdata,
    output logic         o_core_init,
    output logic         o_core_encdec,
    input  logic         i_core_ready,
    input  logic         i_core_valid,
    input  logic [63:0]  i_core_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_INIT, S_WAIT_RDY, S_STREAM, S_DRAIN, S_CRST
    } state_t;

    // Holding register between the input stream and the core
    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        full;
    } wreg_t;

    state_t         r_state;
    logic [2:0]     r_cfg_idx;
    logic [255:0]   r_key;
    logic [63:0]    r_nonce;
    logic           r_busy;
    logic           r_err;
    logic           r_core_rst;
    logic           r_core_we;
    logic [2:0]     r_core_addr;
    logic [63:0]    r_core_wdata;
    logic           r_core_init;
    logic [31:0]    r_word_cnt;
    wreg_t          r_w;

    // Output FIFO: head drives o_m_* directly, tail is the second entry
    logic [63:0]    r_hd_data, r_tl_data;
    logic           r_hd_last, r_tl_last;
    logic           r_hd_vld,  r_tl_vld;

    logic [1:0]     w_fifo_cnt;
    logic           w_fifo_room;
    logic           w_streaming;
    logic           w_encdec;
    logic           w_retire;
    logic           w_s_ready;
    logic           w_accept;
    logic           w_pop;
    logic           w_ovf;
    logic [63:0]    w_setup;
    logic [63:0]    w_cfg_data;

    assign w_fifo_cnt  = {1'b0, r_hd_vld} + {1'b0, r_tl_vld};
    assign w_fifo_room = int'(w_fifo_cnt) < FIFO_DEPTH;
    assign w_streaming = (r_state == S_STREAM);
    assign w_encdec    = w_streaming & r_w.full & w_fifo_room;
    assign w_retire    = w_encdec & i_core_valid;
    // Refill in the retire cycle keeps the stream bubble-free; never refill
    // behind the last word of the message.
    assign w_s_ready   = w_streaming & (!r_w.full | (w_retire & !r_w.last));
    assign w_accept    = i_s_valid & w_s_ready;
    assign w_pop       = r_hd_vld & i_m_ready;
    // Current count equal to the limit means this accept is word MAX_WORDS+1
    assign w_ovf       = (MAX_WORDS != 0) && (r_word_cnt == 32'(MAX_WORDS));
    assign w_setup     = {59'd0, i_cfg_rounds, i_cfg_key256};
    // While in CFG, index k (0..4) selects the next write: KEY0..KEY3 then NONCE
    assign w_cfg_data  = (r_cfg_idx == 3'd4) ? r_nonce
                                             : r_key[{r_cfg_idx[1:0], 6'd0} +: 64];

    // Sequencer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cfg_idx    <= '0;
            r_key        <= '0;
            r_nonce      <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst   <= 1'b1;   // stays high until the first edge after release
            r_core_we    <= 1'b0;
            r_core_addr  <= '0;
            r_core_wdata <= '0;
            r_core_init  <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            r_core_rst  <= 1'b0;
            r_core_init <= 1'b0;
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + 32'd1;
                if (w_ovf) r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_key        <= i_cfg_key;
                    r_nonce      <= i_cfg_nonce;
                    r_err        <= 1'b0;
                    r_word_cnt   <= '0;
                    r_busy       <= 1'b1;
                    r_core_we    <= 1'b1;
                    r_core_addr  <= 3'd5;
                    r_core_wdata <= w_setup;
                    r_cfg_idx    <= '0;
                    r_state      <= S_CFG;
                end
                S_CFG: begin
                    if (r_cfg_idx == 3'd5) begin
                        r_core_we    <= 1'b0;
                        r_core_addr  <= '0;
                        r_core_wdata <= '0;
                        r_core_init  <= 1'b1;
                        r_state      <= S_INIT;
                    end else begin
                        r_core_addr  <= r_cfg_idx;
                        r_core_wdata <= w_cfg_data;
                        r_cfg_idx    <= r_cfg_idx + 3'd1;
                    end
                end
                S_INIT:     r_state <= S_WAIT_RDY;
                S_WAIT_RDY: if (i_core_ready) r_state <= S_STREAM;
                S_STREAM:   if (w_retire && r_w.last) r_state <= S_DRAIN;
                S_DRAIN: if (w_fifo_cnt == 2'd0) begin
                    r_core_rst <= 1'b1;
                    r_state    <= S_CRST;
                end
                S_CRST: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Holding register; a stalled core (core_valid low) leaves it untouched
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_w <= '0;
        end else if (w_accept) begin
            r_w <= '{data: i_s_data, last: i_s_last, full: 1'b1};
        end else if (w_retire) begin
            r_w.full <= 1'b0;
        end
    end

    // Output FIFO. A retire never happens when full (encdec is gated), but
    // push+pop in one cycle is handled in every occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hd_data <= '0;
            r_hd_last <= 1'b0;
            r_hd_vld  <= 1'b0;
            r_tl_data <= '0;
            r_tl_last <= 1'b0;
            r_tl_vld  <= 1'b0;
        end else if (w_pop) begin
            if (r_tl_vld) begin
                r_hd_data <= r_tl_data;
                r_hd_last <= r_tl_last;
                r_tl_vld  <= w_retire;
                if (w_retire) begin
                    r_tl_data <= i_core_out;
                    r_tl_last <= r_w.last;
                end
            end else begin
                r_hd_vld <= w_retire;
                if (w_retire) begin
                    r_hd_data <= i_core_out;
                    r_hd_last <= r_w.last;
                end
            end
        end else if (w_retire) begin
            if (!r_hd_vld) begin
                r_hd_vld  <= 1'b1;
                r_hd_data <= i_core_out;
                r_hd_last <= r_w.last;
            end else begin
                r_tl_vld  <= 1'b1;
                r_tl_data <= i_core_out;
                r_tl_last <= r_w.last;
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_err         = r_err;
    assign o_s_ready     = w_s_ready;
    assign o_m_data      = r_hd_data;
    assign o_m_last      = r_hd_last & r_hd_vld;
    assign o_m_valid     = r_hd_vld;
    assign o_core_rst    = r_core_rst;
    assign o_core_we     = r_core_we;
    assign o_core_addr   = r_core_addr;
    assign o_core_wdata  = w_streaming ? r_w.data : r_core_wdata;
    assign o_core_init   = r_core_init;
    assign o_core_encdec = w_encdec;

endmodule

// File: tb/tb_salsa20_stream_ctrl.sv
`timescale 1ns/1ps
module tb_salsa20_stream_ctrl;
    localparam int MAXW = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] cfg_key = '0;
    logic [63:0]  cfg_nonce = '0;
    logic         cfg_key256 = 1'b0;
    logic [3:0]   cfg_rounds = '0;
    logic         start = 1'b0;
    logic         busy, err;
    logic [63:0]  s_data = '0;
    logic         s_last = 1'b0, s_valid = 1'b0, s_ready;
    logic [63:0]  m_data;
    logic         m_last, m_valid;
    logic         m_ready = 1'b1;
    logic         core_rst, core_we, core_init, core_encdec;
    logic [2:0]   core_addr;
    logic [63:0]  core_wdata, core_out;
    logic         core_ready;
    logic         core_valid = 1'b1;

    always #5 clk = ~clk;

    salsa20_stream_ctrl #(.FIFO_DEPTH(2), .MAX_WORDS(MAXW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_key(cfg_key), .i_cfg_nonce(cfg_nonce),
        .i_cfg_key256(cfg_key256), .i_cfg_rounds(cfg_rounds),
        .i_start(start), .o_busy(busy), .o_err(err),
        .i_s_data(s_data), .i_s_last(s_last), .i_s_valid(s_valid), .o_s_ready(s_ready),
        .o_m_data(m_data), .o_m_last(m_last), .o_m_valid(m_valid), .i_m_ready(m_ready),
        .o_core_rst(core_rst), .o_core_we(core_we), .o_core_addr(core_addr),
        .o_core_wdata(core_wdata), .o_core_init(core_init), .o_core_encdec(core_encdec),
        .i_core_ready(core_ready), .i_core_valid(core_valid), .i_core_out(core_out)
    );

    // Core stand-in: XOR with a keystream indexed by retired word count
    logic [31:0] ks_idx;
    function automatic logic [63:0] ks(input logic [31:0] i);
        return {32'h5A17_0000 + i, 32'hC3D2_E1F0 ^ (i * 32'h9E37_79B9)};
    endfunction
    assign core_out = core_wdata ^ ks(ks_idx);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_idx <= '0; core_ready <= 1'b0;
        end else if (core_rst) begin
            ks_idx <= '0; core_ready <= 1'b0;
        end else begin
            if (core_init) core_ready <= 1'b1;
            if (core_encdec && core_valid) ks_idx <= ks_idx + 32'd1;
        end
    end

    // Monitor: logs handshakes that complete at the following rising edge
    int           cyc = 0;
    logic [66:0]  cfg_q[$];
    int           cfg_cyc[$];
    logic [64:0]  out_q[$];
    int           acc_cyc[$];
    int           n_init = 0, n_crst = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rst_n) begin
        if (core_we) begin cfg_q.push_back({core_addr, core_wdata}); cfg_cyc.push_back(cyc); end
        if (core_init) n_init++;
        if (core_rst) n_crst++;
        if (m_valid && m_ready) out_q.push_back({m_last, m_data});
        if (s_valid && s_ready) acc_cyc.push_back(cyc);
    end

    int n_vec = 0, n_err = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        cfg_q.delete(); cfg_cyc.delete(); out_q.delete(); acc_cyc.delete();
        n_init = 0; n_crst = 0;
    endtask

    task automatic do_start(input logic [255:0] k, input logic [63:0] n,
                            input logic k256, input logic [3:0] r);
        cfg_key = k; cfg_nonce = n; cfg_key256 = k256; cfg_rounds = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_cfg(input logic [255:0] k, input logic [63:0] n,
                           input logic k256, input logic [3:0] r);
        logic [2:0]  ea;
        logic [63:0] ed;
        chk("cfg_nwr", cfg_q.size(), 6);
        if (cfg_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                ea = (i == 0) ? 3'd5 : 3'(i - 1);
                ed = (i == 0) ? {59'd0, r, k256} : (i == 5) ? n : k[64*(i-1) +: 64];
                chk($sformatf("cfg_addr%0d", i), cfg_q[i][66:64], ea);
                chk($sformatf("cfg_data%0d", i), cfg_q[i][63:0], ed);
            end
            chk("cfg_consec", cfg_cyc[5] - cfg_cyc[0], 5);
        end
        chk("init_pulses", n_init, 1);
    endtask

    logic [63:0] msg[$];
    logic [63:0] exp_q[$];

    task automatic send_msg();
        int g;
        for (int i = 0; i < msg.size(); i++) begin
            s_data = msg[i]; s_last = (i == msg.size() - 1); s_valid = 1'b1;
            g = 0;
            @(negedge clk);
            while (!s_ready && g < 300) begin @(negedge clk); g++; end
            if (g >= 300) begin chk("send_timeout", 1, 0); break; end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy && g < 500) begin tick(); g++; end
        chk(tag, busy, 0);
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_cnt"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), out_q[i][63:0], exp_q[i]);
            chk($sformatf("%s_l%0d", tag, i), out_q[i][64], (i == exp_q.size() - 1));
        end
    endtask

    task automatic build(input int n, input logic [31:0] seed);
        msg.delete(); exp_q.delete();
        for (int i = 0; i < n; i++) begin
            msg.push_back({seed + 32'(i), 32'hDEAD_0000 | 32'(i * 7)});
            exp_q.push_back(msg[i] ^ ks(32'(i)));
        end
    endtask

    localparam logic [255:0] KEY_A = {64'hFEDC_BA98_7654_3210, 64'h99AA_BBCC_DDEE_FF00,
                                      64'h1122_3344_5566_7788, 64'h0123_4567_89AB_CDEF};
    localparam logic [63:0]  NON_A = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [255:0] KEY_B = {64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0,
                                      64'h1357_9BDF_2468_ACE0, 64'hCAFE_BABE_DEAD_BEEF};
    localparam logic [63:0]  NON_B = 64'h0000_0001_0000_0002;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] hold;
        logic [63:0] plain[$];
        int g;

        // Reset values
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_we", core_we, 0);
        chk("rst_core_init", core_init, 0);
        chk("rst_encdec", core_encdec, 0);
        chk("rst_addr", core_addr, 0);
        chk("rst_wdata", core_wdata, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mlast", m_last, 0);
        rst_n = 1'b1;
        #1 chk("rel_core_rst_hi", core_rst, 1);
        tick();
        chk("rel_core_rst_lo", core_rst, 0);
        tick(2);

        // 1: configuration sequence
        clr();
        do_start(KEY_A, NON_A, 1'b1, 4'd10);
        chk("t1_busy", busy, 1);
        tick(7);
        chk_cfg(KEY_A, NON_A, 1'b1, 4'd10);
        chk("t1_setup_bits", cfg_q.size() > 0 ? cfg_q[0][4:0] : 5'd0, 5'b10101);

        // 2: 88-word stream, full-rate sink; exceeds MAXW so err sets
        build(88, 32'h1000_0000);
        send_msg();
        wait_idle("t2_idle");
        chk_out("t2");
        chk("t2_b2b", acc_cyc.size() == 88 ? acc_cyc[87] - acc_cyc[0] : -1, 87);
        chk("t2_err", err, 1);
        chk("t2_crst", n_crst, 1);

        // 3: sink backpressure mid-message
        clr();
        do_start(KEY_A, NON_A, 1'b1, 4'd10);
        chk("t3_err_clr", err, 0);
        build(16, 32'h2000_0000);
        fork
            send_msg();
            begin
                g = 0;
                while (out_q.size() < 4 && g < 300) begin tick(); g++; end
                m_ready = 1'b0;
                tick(4);
                chk("t3_encdec_full", core_encdec, 0);
                chk("t3_mvalid", m_valid, 1);
                chk("t3_sready", s_ready, 0);
                hold = m_data;
                tick(6);
                chk("t3_mdata_hold", m_data, hold);
                chk("t3_mvalid_hold", m_valid, 1);
                m_ready = 1'b1;
            end
        join
        wait_idle("t3_idle");
        chk_out("t3");
        chk("t3_err", err, 1);

        // 4: keystream rollover stall; exactly MAXW words, no overflow
        clr();
        do_start(KEY_A, NON_A, 1'b1, 4'd10);
        build(MAXW, 32'h3000_0000);
        fork
            send_msg();
            begin
                g = 0;
                while (acc_cyc.size() < 5 && g < 300) begin tick(); g++; end
                core_valid = 1'b0;
                hold = core_wdata;
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("t4_encdec%0d", i), core_encdec, 1);
                    tick();
                    chk($sformatf("t4_wdata%0d", i), core_wdata, hold);
                end
                core_valid = 1'b1;
            end
        join
        wait_idle("t4_idle");
        chk_out("t4");
        chk("t4_err", err, 0);

        // 5: encrypt then decrypt back-to-back with a new configuration
        clr();
        do_start(KEY_B, NON_B, 1'b0, 4'd8);
        tick(7);
        chk_cfg(KEY_B, NON_B, 1'b0, 4'd8);
        build(8, 32'h4000_0000);
        plain = msg;
        send_msg();
        wait_idle("t5a_idle");
        chk_out("t5a");
        chk("t5a_crst", n_crst, 1);
        msg.delete(); exp_q.delete();
        for (int i = 0; i < out_q.size(); i++) msg.push_back(out_q[i][63:0]);
        exp_q = plain;
        clr();
        do_start(KEY_B, NON_B, 1'b0, 4'd8);
        tick(7);
        chk("t5b_nwr", cfg_q.size(), 6);
        send_msg();
        wait_idle("t5b_idle");
        chk_out("t5b");

        // 6: async reset in the middle of a message
        clr();
        do_start(KEY_A, NON_A, 1'b1, 4'd10);
        s_data = 64'h1234_5678_9ABC_DEF0; s_valid = 1'b1;
        g = 0;
        while (acc_cyc.size() < 3 && g < 300) begin tick(); g++; end
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_sready", s_ready, 0);
        chk("t6_mvalid", m_valid, 0);
        chk("t6_encdec", core_encdec, 0);
        chk("t6_core_rst", core_rst, 1);
        chk("t6_core_we", core_we, 0);
        chk("t6_wdata", core_wdata, 0);
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);
        chk("t6_fifo_empty", m_valid, 0);
        clr();
        do_start(KEY_A, NON_A, 1'b1, 4'd10);
        build(4, 32'h5000_0000);
        send_msg();
        wait_idle("t6_idle");
        chk_out("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
